// File: rtl/fb_pkg.sv
// Shared types and geometry for the framebuffer line-prefetch scheduler.
package fb_pkg;
  localparam int WORDS_PER_LINE = 80;
  localparam int IDX_W          = 7;
  localparam int BANK_W         = 1;
  localparam int LB_ADDR_W      = BANK_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fb_fetch_sched_if.sv
// SRAM port, renderer write port and line-buffer write port of the fetch scheduler.
interface fb_fetch_sched_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  import fb_pkg::*;

  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_we;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    mem_rdata;
  logic                 wr_req;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic                 wr_ack;
  logic                 lb_we;
  logic [LB_ADDR_W-1:0] lb_waddr;
  logic [DATA_W-1:0]    lb_wdata;

  modport master (
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    input  wr_req, wr_addr, wr_data,
    output wr_ack,
    output lb_we, lb_waddr, lb_wdata
  );

  modport slave (
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    output wr_req, wr_addr, wr_data,
    input  wr_ack,
    input  lb_we, lb_waddr, lb_wdata
  );
endinterface

// File: rtl/rd_lat_pipe.sv
// Valid-bit delay line matching the SRAM read latency.
module rd_lat_pipe #(
  parameter int MEM_LAT = 2
) (
  input  logic pixel_clk,
  input  logic reset,
  input  logic vld_in,
  output logic vld_out
);
  logic [MEM_LAT-1:0] vld_p;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= vld_in;
      for (int i = 1; i < MEM_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  assign vld_out = vld_p[MEM_LAT-1];
endmodule

// File: rtl/fb_fetch_sched.sv
// Display line prefetch into a ping-pong line buffer, sharing the SRAM port with one renderer writer.
module fb_fetch_sched
  import fb_pkg::*;
#(
  parameter int              WORDS_PER_LINE = fb_pkg::WORDS_PER_LINE,
  parameter int              ADDR_W         = 16,
  parameter int              DATA_W         = 32,
  parameter int              MEM_LAT        = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic              init_read_line,
  input  logic              v_blank,
  input  logic              line_end,
  fb_fetch_sched_if.master  bus,
  output logic              disp_bank,
  output logic              fetch_busy,
  output logic              underrun
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  fetch_state_t      state_q, state_d;
  logic [IDX_W-1:0]  issue_cnt_q, ret_cnt_q;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic              line_ready_q, vblank_q, reload_pend_q;
  logic              issue_vld_p0, ret_vld;
  logic              last_issue, last_ret, vblank_rise, wr_grant;

  assign issue_vld_p0 = (state_q == ISSUE);
  assign last_issue   = issue_vld_p0 && (issue_cnt_q == LAST_IDX);
  assign last_ret     = ret_vld && (ret_cnt_q == LAST_IDX);
  assign vblank_rise  = v_blank && !vblank_q;
  assign fetch_busy   = (state_q != IDLE);

  // Read-return stage boundary: issue valid delayed by the SRAM latency
  rd_lat_pipe #(.MEM_LAT(MEM_LAT)) u_rd_lat_pipe (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .vld_in    (issue_vld_p0),
    .vld_out   (ret_vld)
  );

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (init_read_line) state_d = ISSUE;
      ISSUE:   if (last_issue)     state_d = DRAIN;
      DRAIN:   if (last_ret)       state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      if (issue_vld_p0) issue_cnt_q <= last_issue ? '0 : issue_cnt_q + 1'b1;
      if (ret_vld)      ret_cnt_q   <= last_ret   ? '0 : ret_cnt_q + 1'b1;
    end
  end

  // A blanking reload is deferred to IDLE so an in-flight line keeps its own addresses
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      fetch_addr_q  <= BASE_ADDR;
      vblank_q      <= 1'b0;
      reload_pend_q <= 1'b0;
    end else begin
      vblank_q <= v_blank;
      if ((state_q == IDLE) && (vblank_rise || reload_pend_q)) begin
        fetch_addr_q  <= BASE_ADDR;
        reload_pend_q <= 1'b0;
      end else begin
        if (vblank_rise)  reload_pend_q <= 1'b1;
        if (issue_vld_p0) fetch_addr_q  <= fetch_addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      line_ready_q <= 1'b0;
      disp_bank    <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      if (line_end && line_ready_q) begin
        disp_bank    <= ~disp_bank;
        line_ready_q <= 1'b0;
      end
      if ((state_q == DRAIN) && last_ret) line_ready_q <= 1'b1;
      if (line_end && !line_ready_q && fetch_busy) underrun <= 1'b1;
      if (init_read_line && fetch_busy)             underrun <= 1'b1;
    end
  end

  // Fetch owns the port in ISSUE; the writer takes IDLE/DRAIN cycles, yielding to a starting fetch
  assign wr_grant = bus.wr_req && (((state_q == IDLE) && !init_read_line) || (state_q == DRAIN));

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = {DATA_W{1'b0}};
    bus.wr_ack    = 1'b0;
    if (issue_vld_p0) begin
      bus.mem_addr = fetch_addr_q;
    end else if (wr_grant) begin
      bus.mem_addr  = bus.wr_addr;
      bus.mem_we    = 1'b1;
      bus.mem_wdata = bus.wr_data;
      bus.wr_ack    = 1'b1;
    end
  end

  assign bus.lb_we    = ret_vld;
  assign bus.lb_waddr = ret_vld ? {~disp_bank, ret_cnt_q} : '0;
  assign bus.lb_wdata = ret_vld ? bus.mem_rdata : {DATA_W{1'b0}};
endmodule

// File: tb/tb_fb_fetch_sched.sv
// Directed scenario bench for fb_fetch_sched with a 2-cycle-latency SRAM model.
module tb_fb_fetch_sched;
  import fb_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic pixel_clk = 1'b0;
  logic reset, init_read_line, v_blank, line_end;
  logic disp_bank, fetch_busy, underrun;
  int   errors = 0;
  int   checks = 0;

  fb_fetch_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_fetch_sched #(
    .WORDS_PER_LINE (80),
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .MEM_LAT        (2),
    .BASE_ADDR      (16'h0000)
  ) dut (
    .pixel_clk      (pixel_clk),
    .reset          (reset),
    .init_read_line (init_read_line),
    .v_blank        (v_blank),
    .line_end       (line_end),
    .bus            (bus),
    .disp_bank      (disp_bank),
    .fetch_busy     (fetch_busy),
    .underrun       (underrun)
  );

  always #5 pixel_clk = ~pixel_clk;

  function automatic logic [31:0] pattern(input logic [15:0] a);
    return {~a, a};
  endfunction

  // SRAM model: read data appears two cycles after its address
  logic [DATA_W-1:0] rd_d1, rd_d2;
  always @(posedge pixel_clk) begin
    rd_d1 <= pattern(bus.mem_addr);
    rd_d2 <= rd_d1;
  end
  assign bus.mem_rdata = rd_d2;

  task automatic fetch_line(input logic [15:0] base, input logic bank, input string tag);
    logic [15:0] ea;
    logic        exp_lb, exp_busy;
    @(negedge pixel_clk); init_read_line = 1'b1; #1;
    for (int i = 1; i <= 84; i++) begin
      @(negedge pixel_clk); init_read_line = 1'b0; #1;
      exp_lb   = (i >= 3) && (i <= 82);
      exp_busy = (i <= 82);
      if (i <= 80) begin
        ea = base + 16'(i - 1);
        checks++;
        if (bus.mem_addr !== ea || bus.mem_we !== 1'b0)
          $display("FAIL %s_addr cyc=%0d got=%h/%b exp=%h/0", tag, i, bus.mem_addr, bus.mem_we, ea);
        if (bus.mem_addr !== ea || bus.mem_we !== 1'b0) errors++;
      end
      checks++;
      if (bus.lb_we !== exp_lb) begin
        errors++;
        $display("FAIL %s_lb_we cyc=%0d got=%b exp=%b", tag, i, bus.lb_we, exp_lb);
      end else if (exp_lb) begin
        ea = base + 16'(i - 3);
        checks++;
        if (bus.lb_waddr !== {bank, 7'(i - 3)} || bus.lb_wdata !== pattern(ea)) begin
          errors++;
          $display("FAIL %s_lb cyc=%0d got=%h/%h exp=%h/%h", tag, i, bus.lb_waddr, bus.lb_wdata,
                   {bank, 7'(i - 3)}, pattern(ea));
        end
      end
      checks++;
      if (fetch_busy !== exp_busy) begin
        errors++;
        $display("FAIL %s_busy cyc=%0d got=%b exp=%b", tag, i, fetch_busy, exp_busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; init_read_line = 1'b0; v_blank = 1'b0; line_end = 1'b0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    repeat (3) @(negedge pixel_clk);
    #1;
    checks++;
    if ({bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.wr_ack} !== '0) begin
      errors++;
      $display("FAIL reset_mem got=%h/%b/%h/%b exp=all 0", bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.wr_ack);
    end
    checks++;
    if ({bus.lb_we, bus.lb_waddr, bus.lb_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_lb got=%b/%h/%h exp=all 0", bus.lb_we, bus.lb_waddr, bus.lb_wdata);
    end
    checks++;
    if ({disp_bank, fetch_busy, underrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b%b%b exp=000", disp_bank, fetch_busy, underrun);
    end
    @(negedge pixel_clk); reset = 1'b0;
  endtask

  task automatic test_fetch();
    fetch_line(16'd0, 1'b1, "fetch");
  endtask

  task automatic test_swap();
    @(negedge pixel_clk); line_end = 1'b1; #1;
    @(negedge pixel_clk); line_end = 1'b0; #1;
    checks++;
    if (disp_bank !== 1'b1) begin errors++; $display("FAIL swap_bank got=%b exp=1", disp_bank); end
    @(negedge pixel_clk); line_end = 1'b1; #1;
    @(negedge pixel_clk); line_end = 1'b0; #1;
    checks++;
    if (disp_bank !== 1'b1 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL swap_idle_le got=%b/%b exp=1/0", disp_bank, underrun);
    end
    fetch_line(16'd80, 1'b0, "swap");
  endtask

  task automatic test_arbitration();
    @(negedge pixel_clk);
    bus.wr_req = 1'b1; bus.wr_addr = 16'h0042; bus.wr_data = 32'hCAFE0042; #1;
    checks++;
    if (bus.wr_ack !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0042 || bus.mem_wdata !== 32'hCAFE0042) begin
      errors++;
      $display("FAIL arb_idle_wr got=%b/%b/%h/%h exp=1/1/0042/cafe0042", bus.wr_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge pixel_clk);
    init_read_line = 1'b1; bus.wr_addr = 16'h1234; bus.wr_data = 32'hDEADBEEF; #1;
    checks++;
    if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL arb_init_wins got=%b exp=0", bus.wr_ack); end
    for (int i = 1; i <= 80; i++) begin
      @(negedge pixel_clk); init_read_line = 1'b0; #1;
      checks++;
      if (bus.wr_ack !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'(160 + i - 1)) begin
        errors++;
        $display("FAIL arb_issue cyc=%0d got=%b/%b/%h exp=0/0/%h", i, bus.wr_ack, bus.mem_we, bus.mem_addr, 16'(160 + i - 1));
      end
    end
    @(negedge pixel_clk); #1;
    checks++;
    if (bus.wr_ack !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h1234 ||
        bus.mem_wdata !== 32'hDEADBEEF || fetch_busy !== 1'b1) begin
      errors++;
      $display("FAIL arb_drain_wr got=%b/%b/%h/%h/%b exp=1/1/1234/deadbeef/1",
               bus.wr_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata, fetch_busy);
    end
    @(negedge pixel_clk); bus.wr_req = 1'b0; #1;
    checks++;
    if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL arb_release got=%b exp=0", bus.wr_ack); end
    for (int k = 0; k < 20 && fetch_busy; k++) begin @(negedge pixel_clk); #1; end
    checks++;
    if (fetch_busy !== 1'b0) begin errors++; $display("FAIL arb_idle_timeout got=%b exp=0", fetch_busy); end
  endtask

  task automatic test_underrun();
    int lb_cnt;
    @(negedge pixel_clk); line_end = 1'b1; #1;
    @(negedge pixel_clk); line_end = 1'b0; #1;
    checks++;
    if (disp_bank !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL ur_pre got=%b/%b exp=0/0", disp_bank, underrun);
    end
    lb_cnt = 0;
    @(negedge pixel_clk); init_read_line = 1'b1; #1;
    for (int i = 1; i <= 100 && (i < 3 || fetch_busy); i++) begin
      @(negedge pixel_clk); init_read_line = 1'b0; line_end = (i == 10); #1;
      if (bus.lb_we === 1'b1) lb_cnt++;
      if (i == 11) begin
        checks++;
        if (underrun !== 1'b1 || disp_bank !== 1'b0) begin
          errors++;
          $display("FAIL ur_flag got=%b/%b exp=1/0", underrun, disp_bank);
        end
      end
    end
    line_end = 1'b0;
    checks++;
    if (fetch_busy !== 1'b0 || lb_cnt != 80) begin
      errors++;
      $display("FAIL ur_finish got=%b/%0d exp=0/80", fetch_busy, lb_cnt);
    end
    checks++;
    if (underrun !== 1'b1 || disp_bank !== 1'b0) begin
      errors++;
      $display("FAIL ur_sticky got=%b/%b exp=1/0", underrun, disp_bank);
    end
  endtask

  task automatic test_reset_mid_drain();
    int lb_cnt;
    @(negedge pixel_clk); init_read_line = 1'b1; #1;
    for (int i = 1; i <= 81; i++) begin @(negedge pixel_clk); init_read_line = 1'b0; #1; end
    reset = 1'b1; #1;
    checks++;
    if (fetch_busy !== 1'b0 || bus.lb_we !== 1'b0 || bus.lb_waddr !== '0 || bus.lb_wdata !== '0 ||
        bus.mem_addr !== '0 || bus.mem_we !== 1'b0 || bus.wr_ack !== 1'b0 || underrun !== 1'b0 || disp_bank !== 1'b0) begin
      errors++;
      $display("FAIL rst_drain got=%b/%b/%h/%h/%b/%b exp=0 all", fetch_busy, bus.lb_we, bus.lb_waddr,
               bus.mem_addr, underrun, disp_bank);
    end
    @(negedge pixel_clk); reset = 1'b0;
    fetch_line(16'd0, 1'b1, "post_rst");
    lb_cnt = 0;
    @(negedge pixel_clk); init_read_line = 1'b1; #1;
    for (int i = 1; i <= 100 && (i < 3 || fetch_busy); i++) begin
      @(negedge pixel_clk); init_read_line = (i == 5); #1;
      if (bus.lb_we === 1'b1) lb_cnt++;
      if (i == 6) begin
        checks++;
        if (underrun !== 1'b1 || bus.mem_addr !== 16'd85) begin
          errors++;
          $display("FAIL busy_init got=%b/%h exp=1/0055", underrun, bus.mem_addr);
        end
      end
    end
    init_read_line = 1'b0;
    checks++;
    if (fetch_busy !== 1'b0 || lb_cnt != 80) begin
      errors++;
      $display("FAIL busy_init_finish got=%b/%0d exp=0/80", fetch_busy, lb_cnt);
    end
  endtask

  task automatic test_frame_wrap();
    logic [15:0] max_addr;
    @(negedge pixel_clk); reset = 1'b1;
    @(negedge pixel_clk); reset = 1'b0;
    max_addr = '0;
    for (int n = 0; n < 480; n++) begin
      @(negedge pixel_clk); init_read_line = 1'b1; #1;
      for (int i = 1; i <= 84; i++) begin
        @(negedge pixel_clk); init_read_line = 1'b0;
        if (n == 479 && i == 10) v_blank = 1'b1;
        #1;
        if (i <= 80 && bus.mem_addr > max_addr) max_addr = bus.mem_addr;
        if (i == 1) begin
          checks++;
          if (bus.mem_addr !== 16'(80 * n)) begin
            errors++;
            $display("FAIL wrap_line_start n=%0d got=%h exp=%h", n, bus.mem_addr, 16'(80 * n));
          end
        end
      end
    end
    checks++;
    if (max_addr !== 16'd38399 || fetch_busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_max got=%0d/%b exp=38399/0", max_addr, fetch_busy);
    end
    @(negedge pixel_clk); init_read_line = 1'b1; #1;
    @(negedge pixel_clk); init_read_line = 1'b0; #1;
    checks++;
    if (bus.mem_addr !== 16'd0 || fetch_busy !== 1'b1) begin
      errors++;
      $display("FAIL wrap_restart got=%h/%b exp=0000/1", bus.mem_addr, fetch_busy);
    end
    for (int k = 0; k < 100 && fetch_busy; k++) begin @(negedge pixel_clk); #1; end
    v_blank = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_swap();
    test_arbitration();
    test_underrun();
    test_reset_mid_drain();
    test_frame_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
